apb_console_sink: RTL

Simulation and FPGA console sink that terminates the SoC's APB UART port in the test harness, in place of a bare mock UART. It decodes a minimal 16550-compatible register subset and buffers transmitted bytes in a FIFO. Bytes drain to a valid/ready character stream. It also produces a per-line completion pulse and a transmitted-byte counter for harness-side checks.

---
 rtl/apb_console_sink.sv | 94 +++++++++
 1 files changed

// File: rtl/apb_console_sink.sv
// apb_console_sink: APB 16550-subset console sink (THR/LSR/SCR) with TX FIFO, char stream, line pulse and byte counter; optional line printing under APB_CONSOLE_PRINT_EN
module apb_console_sink #(
  parameter int FifoDepth  = 16,
  parameter int LineMaxLen = 128
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        line_done_o,
  output logic [31:0] tx_count_o
);
  localparam int AW = $clog2(FifoDepth);
  logic [7:0]  mem_q [FifoDepth];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  scr_q, scr_d, head;
  logic [31:0] tx_count_q, tx_count_d;
  logic        line_done_q, line_done_d;
  logic        access, empty, full, thr_wr, push, pop;
  logic [2:0]  idx;
  // APB decode, FIFO flags and next-state; full is taken from registered pointers so a same-cycle pop never releases a stalled write
  always_comb begin
    idx          = paddr_i[4:2];
    access       = psel_i & penable_i;
    empty        = wptr_q == rptr_q;
    full         = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    thr_wr       = access & pwrite_i & (idx == 3'd0);
    push         = thr_wr & ~full;
    pop          = ~empty & char_ready_i;
    head         = mem_q[rptr_q[AW-1:0]];
    pready_o     = ~(thr_wr & full);
    pslverr_o    = 1'b0;
    char_valid_o = ~empty;
    char_data_o  = empty ? 8'h00 : head;
    prdata_o     = (access & ~pwrite_i) ? (idx == 3'd5 ? {25'b0, empty, ~full, 5'b0} :
                                           idx == 3'd7 ? {24'b0, scr_q} : 32'h0) : 32'h0;
    wptr_d       = wptr_q + (AW+1)'(push);
    rptr_d       = rptr_q + (AW+1)'(pop);
    scr_d        = (access & pwrite_i & (idx == 3'd7)) ? pwdata_i[7:0] : scr_q;
    tx_count_d   = tx_count_q + 32'(pop);
    line_done_d  = pop & (head == 8'h0A);
    line_done_o  = line_done_q;
    tx_count_o   = tx_count_q;
  end
  // Control state: pointers, scratch, counter and line pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      scr_q       <= '0;
      tx_count_q  <= '0;
      line_done_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      scr_q       <= scr_d;
      tx_count_q  <= tx_count_d;
      line_done_q <= line_done_d;
    end
  end
  // FIFO storage needs no reset; the pointers decide what is valid
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= pwdata_i[7:0];
  end
`ifdef APB_CONSOLE_PRINT_EN
  localparam int LW = $clog2(LineMaxLen + 1);
  logic [7:0]    line_q [LineMaxLen];
  logic [LW-1:0] len_q;
  logic          flush;
  assign flush = (head == 8'h0A) || (int'(len_q) + 1 == LineMaxLen);
  // Line length tracking and emission of a completed or full line
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) len_q <= '0;
    else if (pop && flush) begin
      for (int i = 0; i < LineMaxLen; i++) if (i < int'(len_q)) $write("%c", line_q[i]);
      $write("%c", head);
      len_q <= '0;
    end else if (pop) len_q <= len_q + 1'b1;
  end
  // Line buffer storage for bytes not yet emitted
  always_ff @(posedge clk_i) begin
    if (pop && !flush) line_q[len_q] <= head;
  end
`endif
endmodule
